// File: rtl/booth_arb_pkg.sv
// Shared types and defaults for the Booth multiplier front-end arbiter.
// No logic; state encoding, default parameters and id-width helper only.
// Imported by rr_arbiter and booth_arbiter.
package booth_arb_pkg;

  localparam int DEF_OPERAND_BITS   = 4;
  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot grant, search starting just after last_grant.
// Purely combinational, zero latency.
// No backpressure of its own; caller decides when the grant is used.
module rr_arbiter
  import booth_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDW     = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     last_grant,
  output logic [NUM_REQ-1:0] grant
);

  logic [IDW-1:0] idx;
  logic           found;

  // NUM_REQ is a power of two, so the IDW-bit add wraps modulo NUM_REQ.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = last_grant + IDW'(k);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_arbiter.sv
// Arbitrates NUM_REQ requesters onto one shared Booth multiplier, one op in flight.
// Latency: response at T+2+L after accept at T (L = multiplier latency), or T+2+TIMEOUT on abort.
// Backpressure: req_ready only in IDLE; responses are single-cycle pulses with no backpressure.
module booth_arbiter
  import booth_arb_pkg::*;
#(
  parameter  int OPERAND_BITS   = DEF_OPERAND_BITS,
  parameter  int NUM_REQ        = DEF_NUM_REQ,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int IDW            = id_width(NUM_REQ),
  localparam int PW             = 2 * OPERAND_BITS
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*OPERAND_BITS-1:0] req_a,
  input  logic [NUM_REQ*OPERAND_BITS-1:0] req_b,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            mul_start,
  output logic [OPERAND_BITS-1:0]         mul1,
  output logic [OPERAND_BITS-1:0]         mul2,
  input  logic                            mul_done,
  input  logic [PW-1:0]                   mul_res,
  output logic                            rsp_valid,
  output logic [IDW-1:0]                  rsp_id,
  output logic [PW-1:0]                   rsp_data,
  output logic                            rsp_err,
  output logic                            busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  state_t               state, state_nxt;
  logic [NUM_REQ-1:0]   grant;
  logic [IDW-1:0]       last_grant, grant_idx;
  logic [CW-1:0]        cnt;
  logic                 err_q;
  logic                 accept, timeout;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = IDW'(i);
    end
  end

  assign req_ready = (state == IDLE) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  // Fires on the last permitted WAIT cycle; a coincident mul_done still wins.
  assign timeout   = (cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    mul_start = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: begin
        mul_start = 1'b1;
        state_nxt = WAIT;
      end
      WAIT:  if (mul_done || timeout) state_nxt = RESP;
      RESP:  begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      rsp_id     <= '0;
      rsp_data   <= '0;
      mul1       <= '0;
      mul2       <= '0;
      err_q      <= 1'b0;
      cnt        <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          mul1       <= req_a[int'(grant_idx)*OPERAND_BITS +: OPERAND_BITS];
          mul2       <= req_b[int'(grant_idx)*OPERAND_BITS +: OPERAND_BITS];
          rsp_id     <= grant_idx;
          last_grant <= grant_idx;
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (mul_done) begin
            rsp_data <= mul_res;
            err_q    <= 1'b0;
          end else if (timeout) begin
            rsp_data <= '0;
            err_q    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_arbiter.sv
// Bench for booth_arbiter: per-cycle reference model plus multiplier model, directed and random ops.
module tb_booth_arbiter;

  localparam int OB  = 4;
  localparam int N   = 4;
  localparam int TO  = 16;
  localparam int IDW = 2;
  localparam int PW  = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*OB-1:0] req_a, req_b;
  logic [N-1:0]    req_ready;
  logic            mul_start;
  logic [OB-1:0]   mul1, mul2;
  logic            mul_done;
  logic [PW-1:0]   mul_res;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [PW-1:0]   rsp_data;
  logic            rsp_err, busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int lat_cfg = 3;
  bit spur   = 1'b0;
  int rr_exp [5] = '{0, 1, 2, 3, 0};

  // reference model state: at most one operation, described by when it started and how long it takes
  bit            op_active = 1'b0;
  int            op_id, op_t, op_tresp, op_lat;
  logic [OB-1:0] op_a, op_b;
  int            m_last = N - 1;
  bit            in_op;
  logic [N-1:0]  exp_ready;
  logic [PW-1:0] exp_data;
  int            sel;
  bit            pend = 1'b0;
  int            rem  = 0;

  booth_arbiter #(.OPERAND_BITS(OB), .NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .mul_start (mul_start),
    .mul1      (mul1),
    .mul2      (mul2),
    .mul_done  (mul_done),
    .mul_res   (mul_res),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process, reference model and multiplier model, all evaluated at the falling edge.
  initial begin
    mul_done = 1'b0;
    mul_res  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outputs",
            32'({rsp_valid, mul_start, busy, rsp_err, rsp_id, rsp_data, mul1, mul2}), 32'(0));
        op_active = 1'b0;
        m_last    = N - 1;
      end else begin
        in_op = op_active && (cyc > op_t) && (cyc <= op_tresp);
        chk("busy", 32'(busy), 32'(in_op));
        chk("mul_start", 32'(mul_start), 32'(op_active && cyc == op_t + 1));
        chk("rsp_valid", 32'(rsp_valid), 32'(op_active && cyc == op_tresp));
        if (op_active && cyc == op_tresp) begin
          exp_data = (op_lat == 0) ? PW'(0) : PW'(int'($signed(op_a)) * int'($signed(op_b)));
          chk("rsp_id", 32'(rsp_id), 32'(op_id));
          chk("rsp_data", 32'(rsp_data), 32'(exp_data));
          chk("rsp_err", 32'(rsp_err), 32'(op_lat == 0));
        end
        if (in_op) begin
          chk("mul1", 32'(mul1), 32'(op_a));
          chk("mul2", 32'(mul2), 32'(op_b));
        end
        exp_ready = '0;
        sel = -1;
        if (!in_op) begin
          for (int k = 1; k <= N; k++) begin
            if (sel < 0 && req_valid[(m_last + k) % N]) sel = (m_last + k) % N;
          end
          if (sel >= 0) exp_ready[sel] = 1'b1;
        end
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        if (sel >= 0) begin
          op_active = 1'b1;
          op_id     = sel;
          op_a      = req_a[sel*OB +: OB];
          op_b      = req_b[sel*OB +: OB];
          op_t      = cyc;
          op_lat    = lat_cfg;
          op_tresp  = (lat_cfg == 0) ? cyc + 2 + TO : cyc + 2 + lat_cfg;
          m_last    = sel;
        end
      end
      // multiplier: done pulse L cycles after the start pulse; not cancelled by reset
      mul_done = 1'b0;
      if (pend) begin
        rem--;
        if (rem == 0) begin
          mul_done = 1'b1;
          pend     = 1'b0;
        end
      end
      if (rst_n && mul_start && op_lat != 0) begin
        pend = 1'b1;
        rem  = op_lat;
      end
      if (spur) mul_done = 1'b1;
      mul_res = mul_done ? PW'(int'($signed(mul1)) * int'($signed(mul2))) : PW'($urandom);
    end
  end

  task automatic wait_rsp(input int max_cyc, output int t_rsp);
    bit ok;
    ok    = 1'b0;
    t_rsp = -1;
    for (int i = 0; i < max_cyc && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ok    = 1'b1;
        t_rsp = cyc;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles (cycle %0d)", max_cyc, cyc);
    end
  endtask

  task automatic single(input int id, input logic [OB-1:0] a, input logic [OB-1:0] b,
                        input int lat, output int dt, output logic [PW-1:0] d,
                        output logic [IDW-1:0] rid, output logic e);
    int t_acc, t_rsp;
    @(posedge clk); #1;
    lat_cfg             = lat;
    req_a[id*OB +: OB]  = a;
    req_b[id*OB +: OB]  = b;
    req_valid           = N'(1) << id;
    t_acc               = cyc;
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(TO + 10, t_rsp);
    dt  = t_rsp - t_acc;
    d   = rsp_data;
    rid = rsp_id;
    e   = rsp_err;
  endtask

  initial begin
    int             dt, t_r, seen;
    logic [PW-1:0]  d;
    logic [IDW-1:0] rid;
    logic           e;

    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // all requesters held: fresh round-robin order starts at 0
    @(posedge clk); #1;
    lat_cfg   = 2;
    req_a     = {4'd4, 4'd3, 4'd2, 4'd1};
    req_b     = {4'd5, 4'd6, 4'd7, 4'hF};
    req_valid = '1;
    for (int r = 0; r < 5; r++) begin
      wait_rsp(30, t_r);
      chk("rr_order", 32'(rsp_id), 32'(rr_exp[r]));
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (8) @(posedge clk);

    single(2, 4'd3, 4'hE, 6, dt, d, rid, e);
    chk("single_latency", 32'(dt), 32'(8));
    chk("single_id", 32'(rid), 32'(2));
    chk("single_data", 32'(d), 32'(8'hFA));
    chk("single_err", 32'(e), 32'(0));

    single(1, 4'h8, 4'h8, 3, dt, d, rid, e);
    chk("neg8_neg8", 32'(d), 32'(8'h40));
    single(3, 4'h8, 4'h7, 1, dt, d, rid, e);
    chk("neg8_pos7", 32'(d), 32'(8'hC8));

    single(0, 4'd5, 4'd5, 0, dt, d, rid, e);
    chk("timeout_latency", 32'(dt), 32'(18));
    chk("timeout_err", 32'(e), 32'(1));
    chk("timeout_data", 32'(d), 32'(0));
    single(0, 4'd2, 4'd5, 4, dt, d, rid, e);
    chk("after_timeout_data", 32'(d), 32'(8'h0A));
    chk("after_timeout_err", 32'(e), 32'(0));
    chk("after_timeout_latency", 32'(dt), 32'(6));

    // done on the last WAIT cycle beats the timeout
    single(2, 4'd7, 4'd7, 16, dt, d, rid, e);
    chk("done_at_timeout_latency", 32'(dt), 32'(18));
    chk("done_at_timeout_err", 32'(e), 32'(0));
    chk("done_at_timeout_data", 32'(d), 32'(8'h31));

    // spurious mul_done while idle
    @(posedge clk); #1 spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    chk("idle_done_ignored", 32'(seen), 32'(0));

    // reset in the middle of WAIT
    @(posedge clk); #1;
    lat_cfg   = 10;
    req_a     = {4'd1, 4'd6, 4'd1, 4'd1};
    req_b     = {4'd1, 4'd3, 4'd1, 4'd1};
    req_valid = 4'b0100;
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_busy", 32'(busy), 32'(0));
    chk("async_reset_ops", 32'({mul1, mul2}), 32'(0));
    chk("async_reset_rsp", 32'({rsp_valid, rsp_err, rsp_id, rsp_data, mul_start}), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid || busy) seen++;
    end
    chk("no_rsp_after_reset", 32'(seen), 32'(0));

    // randomized traffic; the compare process checks every cycle
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      lat_cfg = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO));
      if ($urandom_range(0, 2) == 0) begin
        req_valid = N'($urandom);
        req_a     = (N*OB)'($urandom);
        req_b     = (N*OB)'($urandom);
      end
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (40) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
